// File: rtl/multicast_dispatch_pkg.sv
// ============================================================================
//  Module      : multicast_dispatch_pkg
//  Description : Shared types and constants for the multicast dispatch block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicast_dispatch_pkg;

    localparam int unsigned CntWidth = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FORK  = 2'd1,
        ERROR = 2'd2
    } dispatch_state_e;

    // Default address, payload and rule types used when the instantiator
    // does not supply its own; end_addr is exclusive.
    typedef logic [31:0] addr_word_t;
    typedef logic [31:0] data_word_t;

    typedef struct packed {
        logic [31:0] idx;
        addr_word_t  start_addr;
        addr_word_t  end_addr;
    } rule_word_t;

endpackage

`default_nettype wire

// File: rtl/multicast_dispatch_decode.sv
// ============================================================================
//  Module      : multiaddr_decode
//  Description : Combinational address decoder; every rule whose
//                [start_addr, end_addr) window contains the address sets the
//                mask bit of its target index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiaddr_decode
    import multicast_dispatch_pkg::*;
#(
    parameter int unsigned NoIndices = 32'd2,
    parameter int unsigned NoRules   = 32'd1,
    parameter type         addr_t    = addr_word_t,
    parameter type         rule_t    = rule_word_t
) (
    input  rule_t [NoRules-1:0] addr_map_i,
    input  addr_t               addr_i,
    output logic [NoIndices-1:0] mask_o,
    output logic                dec_valid_o,
    output logic                dec_error_o
);

    always_comb begin
        mask_o = '0;
        for (int unsigned i = 0; i < NoRules; i++) begin
            for (int unsigned j = 0; j < NoIndices; j++) begin
                if ((addr_i >= addr_map_i[i].start_addr) &&
                    (addr_i <  addr_map_i[i].end_addr) &&
                    (addr_map_i[i].idx == j)) begin
                    mask_o[j] = 1'b1;
                end
            end
        end
    end

    assign dec_valid_o = |mask_o;
    assign dec_error_o = ~dec_valid_o;

endmodule

`default_nettype wire

// File: rtl/multicast_dispatch.sv
// ============================================================================
//  Module      : multicast_dispatch
//  Description : Accepts one request, decodes it against a runtime address
//                map and forks it to every matched target, or reports a
//                decode miss on a handshaked error channel.
//                Optional request/error counters: MULTICAST_DISPATCH_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicast_dispatch
    import multicast_dispatch_pkg::*;
#(
    parameter int unsigned NoIndices = 32'd2,
    parameter int unsigned NoRules   = 32'd1,
    parameter type         addr_t    = addr_word_t,
    parameter type         rule_t    = rule_word_t,
    parameter type         data_t    = data_word_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  rule_t [NoRules-1:0]  addr_map_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  addr_t                addr_i,
    input  data_t                data_i,
    output logic [NoIndices-1:0] valid_o,
    input  logic [NoIndices-1:0] ready_i,
    output data_t                data_o,
    output logic                 err_valid_o,
    input  logic                 err_ready_i,
    output addr_t                err_addr_o,
    output logic [CntWidth-1:0]  cnt_req_o,
    output logic [CntWidth-1:0]  cnt_err_o
);

    if (NoRules == 0) begin : g_bad_rules
        $error("multicast_dispatch: NoRules must be > 0");
    end
    if (NoIndices == 0) begin : g_bad_indices
        $error("multicast_dispatch: NoIndices must be > 0");
    end

    dispatch_state_e      r_state;
    dispatch_state_e      w_state_next;
    logic [NoIndices-1:0] r_pending;
    logic [NoIndices-1:0] w_pending_next;
    logic [NoIndices-1:0] w_mask;
    logic                 w_dec_valid;
    logic                 w_dec_error;
    logic                 w_accept;
    addr_t                r_addr;
    data_t                r_data;

    multiaddr_decode #(
        .NoIndices (NoIndices),
        .NoRules   (NoRules),
        .addr_t    (addr_t),
        .rule_t    (rule_t)
    ) u_decode (
        .addr_map_i  (addr_map_i),
        .addr_i      (addr_i),
        .mask_o      (w_mask),
        .dec_valid_o (w_dec_valid),
        .dec_error_o (w_dec_error)
    );

    wire w_unused = &{1'b0, w_dec_error};

    // ready_o is held low while reset is asserted, even though the state
    // register already reads IDLE.
    assign ready_o  = (r_state == IDLE) && !rst_i;
    assign w_accept = valid_i && ready_o;

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending & ~(valid_o & ready_i);
        valid_o        = '0;
        err_valid_o    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_dec_valid ? FORK : ERROR;
                end
            end
            FORK: begin
                valid_o        = r_pending;
                w_pending_next = r_pending & ~(r_pending & ready_i);
                if (w_pending_next == '0) begin
                    w_state_next = IDLE;
                end
            end
            ERROR: begin
                err_valid_o = 1'b1;
                if (err_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr    <= addr_i;
                r_data    <= data_i;
                r_pending <= w_mask;
            end else if (r_state == FORK) begin
                r_pending <= w_pending_next;
            end
        end
    end

    assign data_o     = r_data;
    assign err_addr_o = r_addr;

`ifdef MULTICAST_DISPATCH_CNT_EN
    logic [CntWidth-1:0] r_cnt_req;
    logic [CntWidth-1:0] r_cnt_err;
    logic                w_to_fork;
    logic                w_to_error;

    assign w_to_fork  = w_accept && w_dec_valid;
    assign w_to_error = w_accept && !w_dec_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt_req <= '0;
            r_cnt_err <= '0;
        end else begin
            if (w_to_fork && (r_cnt_req != '1)) begin
                r_cnt_req <= r_cnt_req + CntWidth'(1);
            end
            if (w_to_error && (r_cnt_err != '1)) begin
                r_cnt_err <= r_cnt_err + CntWidth'(1);
            end
        end
    end

    assign cnt_req_o = r_cnt_req;
    assign cnt_err_o = r_cnt_err;
`else
    assign cnt_req_o = '0;
    assign cnt_err_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicast_dispatch.sv
// ============================================================================
//  Module      : tb_multicast_dispatch
//  Description : Self-checking bench for multicast_dispatch (2 targets,
//                2 rules), directed scenarios plus randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicast_dispatch;
    import multicast_dispatch_pkg::*;

    logic              clk = 1'b0;
    logic              rst_i;
    rule_word_t [1:0]  map;
    logic              valid_i;
    logic              ready_o;
    logic [31:0]       addr_i;
    logic [31:0]       data_i;
    logic [1:0]        valid_o;
    logic [1:0]        ready_i;
    logic [31:0]       data_o;
    logic              err_valid_o;
    logic              err_ready_i;
    logic [31:0]       err_addr_o;
    logic [31:0]       cnt_req_o;
    logic [31:0]       cnt_err_o;

    int total = 0;
    int bad   = 0;
    int exp_req = 0;
    int exp_err = 0;

    multicast_dispatch #(
        .NoIndices (2),
        .NoRules   (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .addr_map_i  (map),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .err_valid_o (err_valid_o),
        .err_ready_i (err_ready_i),
        .err_addr_o  (err_addr_o),
        .cnt_req_o   (cnt_req_o),
        .cnt_err_o   (cnt_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef MULTICAST_DISPATCH_CNT_EN
        return 32'(v);
`else
        return 32'd0;
`endif
    endfunction

    // Set of targets whose windows contain the address.
    function automatic logic [1:0] model_targets(input logic [31:0] a);
        logic [1:0] m;
        m = '0;
        for (int r = 0; r < 2; r++) begin
            if (a >= map[r].start_addr && a < map[r].end_addr) m[map[r].idx[0]] = 1'b1;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rule(input int r, input logic [31:0] idx, input logic [31:0] s, input logic [31:0] e);
        map[r] = '{idx: idx, start_addr: s, end_addr: e};
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d);
        valid_i = 1'b1;
        addr_i  = a;
        data_i  = d;
        tick();
        valid_i = 1'b0;
        addr_i  = $urandom;
        data_i  = $urandom;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = '0; err_ready_i = 1'b0;
        addr_i = '0; data_i = '0; map = '0;
        tick(); tick();
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset ready_o: got %b want 0", ready_o); end
        total++; if (valid_o !== 2'b00) begin bad++; $display("FAIL reset valid_o: got %b want 00", valid_o); end
        total++; if (err_valid_o !== 1'b0) begin bad++; $display("FAIL reset err_valid_o: got %b want 0", err_valid_o); end
        total++; if (cnt_req_o !== 32'd0 || cnt_err_o !== 32'd0) begin bad++; $display("FAIL reset counters: got %0d/%0d want 0/0", cnt_req_o, cnt_err_o); end
        total++; if (data_o !== 32'd0 || err_addr_o !== 32'd0) begin bad++; $display("FAIL reset regs: got data %h addr %h want 0/0", data_o, err_addr_o); end
        rst_i = 1'b0;
        exp_req = 0; exp_err = 0;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL post-reset ready_o: got %b want 1", ready_o); end
    endtask

    task automatic test_single_target();
        logic [31:0] d;
        set_rule(0, 0, 32'h000, 32'h100);
        set_rule(1, 1, 32'h100, 32'h200);
        ready_i = 2'b11;
        d = $urandom;
        send(32'h180, d);
        exp_req++;
        total++; if (valid_o !== 2'b10) begin bad++; $display("FAIL single valid_o: got %b want 10", valid_o); end
        total++; if (data_o !== d) begin bad++; $display("FAIL single data_o: got %h want %h", data_o, d); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL single ready_o busy: got %b want 0", ready_o); end
        tick();
        total++; if (valid_o !== 2'b00) begin bad++; $display("FAIL single valid_o drop: got %b want 00", valid_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL single ready_o back: got %b want 1", ready_o); end
        total++; if (cnt_req_o !== cnt_exp(exp_req)) begin bad++; $display("FAIL single cnt_req: got %0d want %0d", cnt_req_o, cnt_exp(exp_req)); end
        ready_i = '0;
    endtask

    task automatic test_staggered();
        logic [31:0] d;
        set_rule(0, 0, 32'h000, 32'h200);
        set_rule(1, 1, 32'h100, 32'h200);
        ready_i = '0;
        d = $urandom;
        send(32'h150, d);
        exp_req++;
        total++; if (valid_o !== 2'b11) begin bad++; $display("FAIL stagger c1 valid_o: got %b want 11", valid_o); end
        ready_i = 2'b01;
        tick();
        ready_i = 2'b00;
        for (int c = 2; c <= 4; c++) begin
            total++; if (valid_o !== 2'b10) begin bad++; $display("FAIL stagger c%0d valid_o: got %b want 10", c, valid_o); end
            total++; if (data_o !== d) begin bad++; $display("FAIL stagger c%0d data_o: got %h want %h", c, data_o, d); end
            if (c == 4) ready_i = 2'b10;
            tick();
        end
        ready_i = '0;
        total++; if (valid_o !== 2'b00) begin bad++; $display("FAIL stagger end valid_o: got %b want 00", valid_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL stagger end ready_o: got %b want 1", ready_o); end
    endtask

    task automatic test_map_change();
        logic [31:0] d;
        set_rule(0, 0, 32'h000, 32'h200);
        set_rule(1, 1, 32'h100, 32'h200);
        ready_i = '0;
        d = $urandom;
        send(32'h150, d);
        exp_req++;
        set_rule(1, 1, 32'h300, 32'h400);
        for (int c = 0; c < 3; c++) begin
            total++; if (valid_o !== 2'b11) begin bad++; $display("FAIL mapchg c%0d valid_o: got %b want 11", c, valid_o); end
            tick();
        end
        ready_i = 2'b11;
        total++; if (valid_o !== 2'b11) begin bad++; $display("FAIL mapchg final valid_o: got %b want 11", valid_o); end
        tick();
        ready_i = '0;
        total++; if (valid_o !== 2'b00 || ready_o !== 1'b1) begin bad++; $display("FAIL mapchg done: got valid %b ready %b want 00/1", valid_o, ready_o); end
        total++; if (cnt_req_o !== cnt_exp(exp_req)) begin bad++; $display("FAIL mapchg cnt_req: got %0d want %0d", cnt_req_o, cnt_exp(exp_req)); end
    endtask

    task automatic test_decode_miss();
        set_rule(0, 0, 32'h000, 32'h100);
        set_rule(1, 1, 32'h100, 32'h200);
        ready_i = 2'b11;
        err_ready_i = 1'b0;
        send(32'h300, $urandom);
        exp_err++;
        for (int c = 0; c < 3; c++) begin
            total++; if (valid_o !== 2'b00) begin bad++; $display("FAIL miss valid_o: got %b want 00", valid_o); end
            total++; if (err_valid_o !== 1'b1 || err_addr_o !== 32'h300) begin bad++; $display("FAIL miss err: got valid %b addr %h want 1/300", err_valid_o, err_addr_o); end
            total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL miss ready_o: got %b want 0", ready_o); end
            tick();
        end
        err_ready_i = 1'b1;
        tick();
        err_ready_i = 1'b0;
        total++; if (err_valid_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL miss clear: got err %b ready %b want 0/1", err_valid_o, ready_o); end
        total++; if (cnt_err_o !== cnt_exp(exp_err)) begin bad++; $display("FAIL miss cnt_err: got %0d want %0d", cnt_err_o, cnt_exp(exp_err)); end
        ready_i = '0;
    endtask

    task automatic test_reset_mid_fork();
        logic [31:0] d;
        set_rule(0, 0, 32'h000, 32'h200);
        set_rule(1, 1, 32'h100, 32'h200);
        ready_i = '0;
        send(32'h150, $urandom);
        ready_i = 2'b01;
        tick();
        ready_i = 2'b00;
        total++; if (valid_o !== 2'b10) begin bad++; $display("FAIL rstfork pre valid_o: got %b want 10", valid_o); end
        rst_i = 1'b1;
        tick();
        total++; if (valid_o !== 2'b00 || err_valid_o !== 1'b0) begin bad++; $display("FAIL rstfork valids: got %b/%b want 00/0", valid_o, err_valid_o); end
        total++; if (cnt_req_o !== 32'd0 || cnt_err_o !== 32'd0) begin bad++; $display("FAIL rstfork counters: got %0d/%0d want 0/0", cnt_req_o, cnt_err_o); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL rstfork ready_o in reset: got %b want 0", ready_o); end
        rst_i = 1'b0;
        exp_req = 0; exp_err = 0;
        tick();
        total++; if (valid_o !== 2'b00 || ready_o !== 1'b1) begin bad++; $display("FAIL rstfork idle: got valid %b ready %b want 00/1", valid_o, ready_o); end
        ready_i = 2'b11;
        d = $urandom;
        send(32'h050, d);
        exp_req++;
        total++; if (valid_o !== 2'b01 || data_o !== d) begin bad++; $display("FAIL rstfork redispatch: got %b/%h want 01/%h", valid_o, data_o, d); end
        tick();
        total++; if (valid_o !== 2'b00 || cnt_req_o !== cnt_exp(exp_req)) begin bad++; $display("FAIL rstfork after: got valid %b cnt %0d want 00/%0d", valid_o, cnt_req_o, cnt_exp(exp_req)); end
        ready_i = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int hs;
        set_rule(0, 0, 32'h000, 32'h100);
        set_rule(1, 1, 32'h100, 32'h200);
        ready_i = 2'b11;
        hs = 0;
        valid_i = 1'b1;
        addr_i = 32'h050;
        for (int k = 0; k < 10; k++) begin
            d = $urandom;
            data_i = d;
            total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b %0d ready_o: got %b want 1", k, ready_o); end
            tick();
            exp_req++;
            total++; if (valid_o !== 2'b01 || data_o !== d) begin bad++; $display("FAIL b2b %0d fork: got %b/%h want 01/%h", k, valid_o, data_o, d); end
            if (valid_o[0] && ready_i[0]) hs++;
            data_i = $urandom;
            tick();
        end
        valid_i = 1'b0;
        total++; if (hs !== 10) begin bad++; $display("FAIL b2b handshakes: got %0d want 10", hs); end
        total++; if (cnt_req_o !== cnt_exp(exp_req)) begin bad++; $display("FAIL b2b cnt_req: got %0d want %0d", cnt_req_o, cnt_exp(exp_req)); end
        ready_i = '0;
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [1:0]  pend;
        logic        done;
        int          n;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 2; r++) begin
                logic [31:0] s;
                s = 32'($urandom_range(0, 32'h300));
                set_rule(r, 32'($urandom_range(0, 1)), s, s + 32'($urandom_range(1, 32'h100)));
            end
            a = 32'($urandom_range(0, 32'h3ff));
            d = $urandom;
            pend = model_targets(a);
            total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rand %0d idle ready_o: got %b want 1", it, ready_o); end
            send(a, d);
            n = 0;
            if (pend == 2'b00) begin
                exp_err++;
                done = 1'b0;
                while (!done && n < 50) begin
                    total++; if (err_valid_o !== 1'b1 || err_addr_o !== a || valid_o !== 2'b00) begin bad++; $display("FAIL rand %0d err: got %b/%h/%b want 1/%h/00", it, err_valid_o, err_addr_o, valid_o, a); end
                    err_ready_i = 1'($urandom_range(0, 1));
                    done = err_ready_i;
                    tick();
                    n++;
                end
                err_ready_i = 1'b0;
                total++; if (!done || err_valid_o !== 1'b0) begin bad++; $display("FAIL rand %0d err clear: got err %b want 0", it, err_valid_o); end
            end else begin
                exp_req++;
                while (pend != 2'b00 && n < 100) begin
                    total++; if (valid_o !== pend || data_o !== d || ready_o !== 1'b0) begin bad++; $display("FAIL rand %0d fork: got %b/%h/%b want %b/%h/0", it, valid_o, data_o, ready_o, pend, d); end
                    ready_i = 2'($urandom_range(0, 3));
                    map[$urandom_range(0, 1)].end_addr = $urandom;
                    pend = pend & ~ready_i;
                    tick();
                    n++;
                end
                ready_i = '0;
                total++; if (pend != 2'b00 || valid_o !== 2'b00) begin bad++; $display("FAIL rand %0d fork end: got %b want 00", it, valid_o); end
            end
            total++; if (cnt_req_o !== cnt_exp(exp_req) || cnt_err_o !== cnt_exp(exp_err)) begin bad++; $display("FAIL rand %0d counters: got %0d/%0d want %0d/%0d", it, cnt_req_o, cnt_err_o, cnt_exp(exp_req), cnt_exp(exp_err)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_target();
        test_staggered();
        test_map_change();
        test_decode_miss();
        test_reset_mid_fork();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
